fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding N requesters into one FIFO write port
// Ports: clk / i_rst (async, active-high) | i_req, i_last, i_data: per-requester beat valid,
// last flag and packed beat data | o_ack: one-hot beat accept | i_fifo_full, o_fifo_wen,
// o_fifo_data: FIFO write side | o_src_id: current owner | o_busy: grant held.
// Define FIFO_ARB_BURST_LIMIT_EN to force release after MAX_BURST accepted beats per grant.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int MAX_BURST  = 16,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    output logic [NUM_REQ-1:0]            o_ack,
    input  logic                          i_fifo_full,
    output logic                          o_fifo_wen,
    output logic [DATA_WIDTH-1:0]         o_fifo_data,
    output logic [ID_WIDTH-1:0]           o_src_id,
    output logic                          o_busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              r_state;
    logic [IW-1:0]       r_owner;
    logic [IW-1:0]       r_rr_ptr;
    logic                w_req_own;
    logic                w_last_own;
    logic [DATA_WIDTH-1:0] w_data_own;
    logic [2*NUM_REQ-1:0] w_rot;
    logic [IW-1:0]       w_off;
    logic [IW:0]         w_sum;
    logic [IW:0]         w_pick_full;
    logic [IW-1:0]       w_pick;
    logic                w_wen;
    logic                w_release;

    always_comb begin
        w_req_own  = 1'b0;
        w_last_own = 1'b0;
        w_data_own = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_owner == IW'(k)) begin
                w_req_own  = i_req[k];
                w_last_own = i_last[k];
                w_data_own = i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is then the offset of the winner.
    assign w_rot = {i_req, i_req} >> r_rr_ptr;

    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = IW'(i);
        end
    end

    assign w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_pick_full = (w_sum >= NR) ? w_sum - NR : w_sum;
    assign w_pick      = w_pick_full[IW-1:0];

    assign w_wen = (r_state == BURST) && w_req_own && !i_fifo_full;

`ifdef FIFO_ARB_BURST_LIMIT_EN
    localparam int CW = ($clog2(MAX_BURST) + 1 > 8) ? $clog2(MAX_BURST) + 1 : 8;
    logic [CW-1:0] r_cnt;
    // Counter holds beats already accepted, so the MAX_BURST-th beat sees MAX_BURST-1.
    assign w_release = w_last_own || (r_cnt == CW'(MAX_BURST - 1));
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else
            r_cnt <= (r_state == IDLE) ? '0 : w_wen ? r_cnt + 1'b1 : r_cnt;
    end
`else
    assign w_release = w_last_own;
`endif

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else if (r_state == IDLE) begin
            if (|i_req) begin
                r_owner <= w_pick;
                r_state <= BURST;
            end
        end else if (w_wen && w_release) begin
            r_state  <= IDLE;
            r_rr_ptr <= (r_owner == LAST_ID) ? '0 : r_owner + 1'b1;
        end
    end

    assign o_fifo_wen  = w_wen;
    assign o_ack       = w_wen ? NUM_REQ'(1) << r_owner : '0;
    assign o_fifo_data = w_data_own;
    assign o_src_id    = ID_WIDTH'(r_owner);
    assign o_busy      = (r_state == BURST);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          i_rst;
    logic [N-1:0]  i_req;
    logic [N-1:0]  i_last;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]  o_ack;
    logic          i_fifo_full;
    logic          o_fifo_wen;
    logic [DW-1:0] o_fifo_data;
    logic [1:0]    o_src_id;
    logic          o_busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4), .ID_WIDTH(2)) dut (
        .clk(clk), .i_rst(i_rst), .i_req(i_req), .i_last(i_last), .i_data(i_data),
        .o_ack(o_ack), .i_fifo_full(i_fifo_full), .o_fifo_wen(o_fifo_wen),
        .o_fifo_data(o_fifo_data), .o_src_id(o_src_id), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int q[$];
    int mon_e;
    int nb[N];
    int bi[N];
    int blen[N];
    bit en[N];
    bit fullv;
    logic       s_wen;
    logic       s_busy;
    logic [1:0] s_src;
    logic [N-1:0] s_ack;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp_);
        checks++;
        if (act !== exp_) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp_);
        end
    endtask

    task automatic push(input int src, input int d);
        q.push_back(src * 65536 + d);
    endtask

    task automatic clr();
        for (int k = 0; k < N; k++) begin
            nb[k] = 0;
            bi[k] = 0;
            blen[k] = 1;
            en[k] = 1'b1;
        end
        fullv = 1'b0;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            i_req[k]  = en[k] && nb[k] > 0;
            i_last[k] = blen[k] != 0 && ((bi[k] + 1) % blen[k] == 0);
            i_data[k*DW +: DW] = 16'(k * 4096 + bi[k]);
        end
        i_fifo_full = fullv;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #3;
        s_wen  = o_fifo_wen;
        s_busy = o_busy;
        s_src  = o_src_id;
        s_ack  = o_ack;
        for (int k = 0; k < N; k++) begin
            if (o_ack[k]) begin
                nb[k]--;
                bi[k]++;
            end
        end
    endtask

    function automatic int pending();
        int p = 0;
        for (int k = 0; k < N; k++) p += nb[k];
        return p;
    endfunction

    task automatic run_done(input int maxc);
        int c = 0;
        while (pending() > 0 && c < maxc) begin
            step();
            c++;
        end
        chk("run_bound_beats_left", pending(), 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        clr();
        repeat (2) step();
        i_rst = 1'b0;
    endtask

    // Scoreboard monitor: every FIFO write must match the next hand-computed beat.
    always @(negedge clk) begin
        #3;
        if (o_fifo_wen) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got src=%0d data=0x%0h expected no write", o_src_id, o_fifo_data);
            end else begin
                mon_e = q.pop_front();
                chk("write_src_data", {14'd0, o_src_id, o_fifo_data}, mon_e);
                chk("write_ack", 32'(o_ack), 32'(1) << (mon_e >> 16));
            end
            chk("wen_while_full", 32'(i_fifo_full), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1;
        clr();
        drive();
        #1;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_wen", 32'(o_fifo_wen), 0);
        chk("rst_ack", 32'(o_ack), 0);
        chk("rst_src", 32'(o_src_id), 0);
        repeat (2) step();
        i_rst = 1'b0;

        // single requester, 3-beat burst
        nb[0] = 3;
        blen[0] = 3;
        push(0, 0); push(0, 1); push(0, 2);
        step();
        chk("s1_idle_wen", 32'(s_wen), 0);
        chk("s1_idle_busy", 32'(s_busy), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s1_wen", 32'(s_wen), 1);
            chk("s1_src", 32'(s_src), 0);
        end
        step();
        chk("s1_busy_after", 32'(s_busy), 0);

        // round robin, all requesting 1-beat bursts
        do_reset();
        nb[0] = 2; nb[1] = 1; nb[2] = 1; nb[3] = 1;
        push(0, 16'h0000); push(1, 16'h1000); push(2, 16'h2000); push(3, 16'h3000); push(0, 16'h0001);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("s2_wen_pattern", 32'(s_wen), i % 2);
        end

        // backpressure mid-burst
        do_reset();
        nb[1] = 6;
        blen[1] = 6;
        for (int d = 0; d < 6; d++) push(1, 16'h1000 + d);
        repeat (3) step();
        fullv = 1'b1;
        repeat (5) begin
            step();
            chk("s3_full_wen", 32'(s_wen), 0);
            chk("s3_full_ack", 32'(s_ack), 0);
            chk("s3_full_busy", 32'(s_busy), 1);
        end
        fullv = 1'b0;
        run_done(20);

        // owner stall while another requester waits
        do_reset();
        nb[0] = 4; blen[0] = 4;
        nb[2] = 1; blen[2] = 1; en[2] = 1'b0;
        for (int d = 0; d < 4; d++) push(0, d);
        push(2, 16'h2000);
        repeat (2) step();
        en[0] = 1'b0;
        en[2] = 1'b1;
        repeat (3) begin
            step();
            chk("s4_stall_wen", 32'(s_wen), 0);
            chk("s4_stall_src", 32'(s_src), 0);
            chk("s4_stall_busy", 32'(s_busy), 1);
        end
        en[0] = 1'b1;
        run_done(20);

`ifdef FIFO_ARB_BURST_LIMIT_EN
        // burst limit of 4 beats without i_last
        do_reset();
        nb[0] = 12; blen[0] = 0;
        nb[1] = 1;  blen[1] = 1;
        for (int d = 0; d < 4; d++) push(0, d);
        push(1, 16'h1000);
        for (int d = 4; d < 12; d++) push(0, d);
        run_done(60);
`endif

        // async reset mid-burst, then requester 2 wins first
        do_reset();
        nb[0] = 4;
        blen[0] = 4;
        push(0, 0);
        repeat (2) step();
        @(negedge clk);
        drive();
        #1;
        i_rst = 1'b1;
        #1;
        chk("s6_rst_busy", 32'(o_busy), 0);
        chk("s6_rst_wen", 32'(o_fifo_wen), 0);
        chk("s6_rst_ack", 32'(o_ack), 0);
        clr();
        repeat (2) step();
        i_rst = 1'b0;
        nb[2] = 1;
        push(2, 16'h2000);
        step();
        chk("s6_idle_busy", 32'(s_busy), 0);
        step();
        chk("s6_grant_busy", 32'(s_busy), 1);
        chk("s6_grant_src", 32'(s_src), 2);
        chk("s6_grant_wen", 32'(s_wen), 1);

        repeat (3) step();
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
